memory_access_unit: RTL

- Consumes the output side of the execute/memory pipeline latch: load/store/atomic controls, ALU address and store data.
- Drives the per-core dcache request port and resolves LL/SC through a link register with snoop invalidation.
- Returns the load or SC result, and a ready/stall pair to the hazard unit, which controls the memory/writeback latch update.

---
 rtl/my_types_pkg.sv | 14 +
 rtl/link_reg.sv | 63 ++++++
 rtl/memory_access_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/my_types_pkg.sv
// Shared types and constants for the memory access stage.
package my_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HOLD
  } mem_state_t;

  // Store-conditional status values returned on mem_result[0].
  localparam logic SC_PASS = 1'b1;
  localparam logic SC_FAIL = 1'b0;

endpackage

// File: rtl/link_reg.sv
// LL/SC reservation register with snoop invalidation and word-granular compare.
module link_reg #(
  parameter int unsigned WordW = 32,
  parameter int unsigned OffW  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ll_set_i,    // LL completes this cycle
  input  logic             sc_done_i,   // SC completes (pass or fail) this cycle
  input  logic             st_done_i,   // plain store completes this cycle
  input  logic [WordW-1:0] op_addr_i,
  input  logic             inv_i,
  input  logic [WordW-1:0] inv_addr_i,
  output logic             link_valid_o,
  output logic [WordW-1:0] link_addr_o,
  output logic             sc_ok_o
);

  logic             link_valid_q, link_valid_d;
  logic [WordW-1:0] link_addr_q, link_addr_d;
  logic             inv_hit_cur, inv_hit_new, st_hit;

  function automatic logic word_eq(input logic [WordW-1:0] a, input logic [WordW-1:0] b);
    return ((a ^ b) >> OffW) == '0;
  endfunction

  // Hit detection; SC sees the reservation after any same-cycle invalidate.
  always_comb begin
    inv_hit_cur = inv_i & link_valid_q & word_eq(inv_addr_i, link_addr_q);
    inv_hit_new = inv_i & ll_set_i & word_eq(inv_addr_i, op_addr_i);
    st_hit      = st_done_i & word_eq(op_addr_i, link_addr_q);
    sc_ok_o     = link_valid_q & word_eq(link_addr_q, op_addr_i) & ~inv_hit_cur;
  end

  // Next reservation: invalidate beats SC/store clear, which beat LL set.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (ll_set_i) link_addr_d = op_addr_i;
    if (inv_hit_cur || inv_hit_new) begin
      link_valid_d = 1'b0;
    end else if (sc_done_i || st_hit) begin
      link_valid_d = 1'b0;
    end else if (ll_set_i) begin
      link_valid_d = 1'b1;
    end
  end

  // Reservation state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign link_valid_o = link_valid_q;
  assign link_addr_o  = link_addr_q;

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage: dcache request FSM, LL/SC resolution and hazard handshake.
module memory_access_unit
  import my_types_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned OFF_W  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              op_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              atomic,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              advance,
  input  logic              flush,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] mem_result,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              link_valid,
  output logic [WORD_W-1:0] link_addr
);

  mem_state_t        state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  logic [WORD_W-1:0] result_r_q, result_r_d;

  logic              present, is_read, is_write, is_sc, sc_ok, sc_fail;
  logic              ren, wen, ready, ll_set, sc_done, st_done, complete;
  logic [WORD_W-1:0] result, done_val;

  // Decode the latched op; a read takes precedence if both flags are set.
  always_comb begin
    present  = op_valid & (mem_read | mem_write);
    is_read  = present & mem_read;
    is_write = present & mem_write & ~mem_read;
    is_sc    = is_write & atomic;
    sc_fail  = is_sc & ~sc_ok;
    done_val = is_read ? dmemload
             : is_sc   ? {{(WORD_W-1){1'b0}}, SC_PASS}
             : '0;
  end

  // Next-state, request and result logic.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    result_r_d   = result_r_q;
    ren          = 1'b0;
    wen          = 1'b0;
    ready        = 1'b0;
    result       = result_r_q;
    complete     = 1'b0;
    sc_done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!present) begin
          ready = 1'b1;
        end else if (flush) begin
          ready = 1'b0;
        end else if (sc_fail) begin
          // Fail locally without touching the cache.
          ready   = 1'b1;
          result  = {{(WORD_W-1){1'b0}}, SC_FAIL};
          sc_done = 1'b1;
        end else begin
          ren = is_read;
          wen = is_write;
          if (dhit) begin
            ready      = 1'b1;
            result     = done_val;
            result_r_d = done_val;
            complete   = 1'b1;
            state_d    = advance ? IDLE : HOLD;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An issued request is never aborted; a flush only discards its result.
        ren = is_read;
        wen = is_write;
        if (dhit) begin
          if (flush_pend_q || flush) begin
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end else begin
            ready      = 1'b1;
            result     = done_val;
            result_r_d = done_val;
            complete   = 1'b1;
            state_d    = advance ? IDLE : HOLD;
          end
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          ready   = 1'b1;
          result  = result_r_q;
          if (advance) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (complete && is_sc) sc_done = 1'b1;
  end

  always_comb begin
    ll_set  = complete & is_read & atomic;
    st_done = complete & is_write & ~atomic;
  end

  // FSM and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      result_r_q   <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      result_r_q   <= result_r_d;
    end
  end

  link_reg #(
    .WordW (WORD_W),
    .OffW  (OFF_W)
  ) u_link_reg (
    .clk_i        (CLK),
    .rst_i        (RST),
    .ll_set_i     (ll_set & ~RST),
    .sc_done_i    (sc_done & ~RST),
    .st_done_i    (st_done & ~RST),
    .op_addr_i    (addr),
    .inv_i        (ccinv),
    .inv_addr_i   (ccsnoopaddr),
    .link_valid_o (link_valid),
    .link_addr_o  (link_addr),
    .sc_ok_o      (sc_ok)
  );

  // Outputs are held quiet while reset is asserted.
  always_comb begin
    dmemREN    = ren & ~RST;
    dmemWEN    = wen & ~RST;
    mem_ready  = ready & ~RST;
    mem_stall  = present & ~ready & ~RST;
    mem_result = result;
    dmemaddr   = {addr[WORD_W-1:OFF_W], {OFF_W{1'b0}}};
    dmemstore  = wdata;
  end

endmodule
